res_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 16384x8 result RAM (res_* interface).
- Lets the distance-transform engine (port 0) and a result readback/debug client (port 1) share the RAM without collisions.
- Round-robin arbitration with an optional lock for read-modify-write bursts, a fixed read-return pipeline, and a lock-timeout error flag.

---
 rtl/res_mem_pkg.sv | 15 +
 rtl/rr_arb2.sv | 33 +++
 rtl/res_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_res_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/res_mem_pkg.sv
// Shared types and constants for the result-RAM arbiter.
// The RAM holds a 128x128 image, row-major {y,x}, one byte per pixel.
package res_mem_pkg;
    localparam int AW_DEF       = 14;
    localparam int DW_DEF       = 8;
    localparam int IMG_W        = 128;
    localparam int RD_LAT       = 3;
    localparam int LOCK_MAX_DEF = 16;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with an eligibility mask and combinational grant.
// The most recently granted port loses the next contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic [1:0] i_elig,
    output logic [1:0] o_gnt
);
    logic       r_rr_last;
    logic [1:0] w_req;

    // Grants are suppressed while reset is held so every output reads 0.
    assign w_req = i_req & i_elig & {2{reset}};

    always_comb begin
        o_gnt = 2'b00;
        case (w_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_rr_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_last <= 1'b1;
        end else if (|o_gnt) begin
            r_rr_last <= o_gnt[1];
        end
    end
endmodule

// File: rtl/res_mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port result RAM: round-robin
// grants, lock bursts with timeout, and a tagged fixed-latency read return.
module res_mem_arbiter
    import res_mem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          wr0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          wr1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          res_wr,
    output logic          res_rd,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_do,
    input  logic [DW-1:0] res_di,
    output logic          busy,
    output logic          lock_err
);
    localparam int            CW      = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [1:0]    w_elig;
    logic [1:0]    w_gnt;
    logic          w_any;
    logic          w_sel;
    logic          w_g_wr;
    logic          w_g_lock;
    logic          w_own_lock;
    logic          w_err_set;
    logic [AW-1:0] w_g_addr;
    logic [DW-1:0] w_g_wdata;
    logic          r_vld_p1;
    logic          r_tag_p1;
    logic          r_vld_p2;
    logic          r_tag_p2;

    assign w_elig = (r_state == LOCK0) ? 2'b01 :
                    (r_state == LOCK1) ? 2'b10 : 2'b11;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .i_req  ({req1, req0}),
        .i_elig (w_elig),
        .o_gnt  (w_gnt)
    );

    assign gnt0       = w_gnt[0];
    assign gnt1       = w_gnt[1];
    assign w_any      = |w_gnt;
    assign w_sel      = w_gnt[1];
    assign w_g_wr     = w_sel ? wr1    : wr0;
    assign w_g_lock   = w_sel ? lock1  : lock0;
    assign w_g_addr   = w_sel ? addr1  : addr0;
    assign w_g_wdata  = w_sel ? wdata1 : wdata0;
    assign w_own_lock = (r_state == LOCK1) ? lock1 : lock0;
    assign w_cnt_inc  = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        case (r_state)
            ARB: begin
                if (w_any && w_g_lock) begin
                    w_state_nxt = w_sel ? LOCK1 : LOCK0;
                    w_cnt_nxt   = CW'(1);
                end
            end
            LOCK0, LOCK1: begin
                if (w_any) begin
                    if (!w_g_lock) begin
                        w_state_nxt = ARB;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        // Burst hit its ceiling: release the lock so the other port gets a turn.
                        w_state_nxt = ARB;
                        w_cnt_nxt   = '0;
                        w_err_set   = 1'b1;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end else if (!w_own_lock) begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state != ARB) | r_vld_p1 | r_vld_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ARB;
            r_cnt    <= '0;
            lock_err <= 1'b0;
            res_wr   <= 1'b0;
            res_rd   <= 1'b0;
            res_addr <= '0;
            res_do   <= '0;
            r_vld_p1 <= 1'b0;
            r_tag_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_tag_p2 <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            lock_err <= lock_err | w_err_set;
            // p1: command presented to the RAM, owner tag travels with the read strobe
            res_wr   <= w_any & w_g_wr;
            res_rd   <= w_any & ~w_g_wr;
            if (w_any) begin
                res_addr <= w_g_addr;
                res_do   <= w_g_wdata;
            end
            r_vld_p1 <= w_any & ~w_g_wr;
            r_tag_p1 <= w_sel;
            // p2: RAM output valid on res_di
            r_vld_p2 <= r_vld_p1;
            r_tag_p2 <= r_tag_p1;
            // p3: read data returned to the tagged port
            rvalid0  <= r_vld_p2 & ~r_tag_p2;
            rvalid1  <= r_vld_p2 &  r_tag_p2;
            if (r_vld_p2 && !r_tag_p2) rdata0 <= res_di;
            if (r_vld_p2 &&  r_tag_p2) rdata1 <= res_di;
        end
    end
endmodule

// File: tb/tb_res_mem_arbiter.sv
// Self-checking bench for res_mem_arbiter: directed scenarios plus random
// traffic, checked every cycle against a rule-level reference model.
module tb_res_mem_arbiter;
    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, wr0 = 1'b0, lock0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] wdata0 = '0;
    logic          req1 = 1'b0, wr1 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          res_wr, res_rd, busy, lock_err;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_do;
    logic [DW-1:0] res_di;

    res_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .wr0(wr0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .wr1(wr1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .res_wr(res_wr), .res_rd(res_rd), .res_addr(res_addr), .res_do(res_do),
        .res_di(res_di), .busy(busy), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        if (a == 32'h81) return 8'h05;
        return 8'(a ^ (a >> 6));
    endfunction

    // Single-port RAM: write and read sampled on the clock, read data next cycle.
    logic [7:0] ram [0:16383];
    bit         ram_ready;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 16384; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (res_wr) begin
            ram[res_addr] <= res_do;
        end
        if (res_rd) res_di <= ram[res_addr];
    end

    typedef struct {
        int       due;
        bit       port;
        logic [7:0] data;
    } rd_t;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            own_m, rr_m, run_m;
    bit            err_m, rd_prev1, rd_prev2;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_do;
    logic [7:0]    shadow [0:16383];
    rd_t           sb[$];

    logic          snap_gnt0, snap_gnt1, snap_rd, snap_wr, snap_rv0, snap_rv1, snap_busy, snap_err;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_do, snap_rd0, snap_rd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {18'b0, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
                res_wr, res_rd, res_addr, res_do, busy, lock_err};
    endfunction

    function automatic logic [AW-1:0] raddr();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic model_init();
        own_m = -1; rr_m = 1; run_m = 0; err_m = 1'b0;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_do = '0;
        rd_prev1 = 1'b0; rd_prev2 = 1'b0;
        sb.delete();
    endtask

    task automatic check_cycle();
        int            g;
        bit            e0, e1, rv0, rv1, lk, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rdx;
        logic [1:0]    eg;
        snap_gnt0 = gnt0; snap_gnt1 = gnt1; snap_rd = res_rd; snap_wr = res_wr;
        snap_addr = res_addr; snap_do = res_do; snap_rv0 = rvalid0; snap_rv1 = rvalid1;
        snap_rd0 = rdata0; snap_rd1 = rdata1; snap_busy = busy; snap_err = lock_err;

        chk("res_rd", res_rd, e_rd);
        chk("res_wr", res_wr, e_wr);
        chk("res_addr", res_addr, e_addr);
        chk("res_do", res_do, e_do);

        rv0 = 1'b0; rv1 = 1'b0; rdx = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (sb[0].port) rv1 = 1'b1; else rv0 = 1'b1;
            rdx = sb[0].data;
            void'(sb.pop_front());
        end
        chk("rvalid0", rvalid0, rv0);
        chk("rvalid1", rvalid1, rv1);
        if (rv0) chk("rdata0", rdata0, rdx);
        if (rv1) chk("rdata1", rdata1, rdx);
        chk("busy", busy, ((own_m >= 0) || rd_prev1 || rd_prev2) ? 1 : 0);
        chk("lock_err", lock_err, err_m);

        e0 = req0 && (own_m != 1);
        e1 = req1 && (own_m != 0);
        g = -1;
        if (e0 && e1)  g = (rr_m == 0) ? 1 : 0;
        else if (e0)   g = 0;
        else if (e1)   g = 1;
        eg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        chk("gnt", {gnt1, gnt0}, eg);

        w = 1'b0;
        if (g >= 0) begin
            lk = (g == 1) ? lock1 : lock0;
            w  = (g == 1) ? wr1 : wr0;
            a  = (g == 1) ? addr1 : addr0;
            d  = (g == 1) ? wdata1 : wdata0;
            rr_m = g;
            e_rd = !w; e_wr = w; e_addr = a; e_do = d;
            if (!w) sb.push_back('{cyc + 3, (g == 1), shadow[a]});
            else    shadow[a] = d;
            if (own_m < 0) begin
                if (lk) begin own_m = g; run_m = 1; end
            end else begin
                run_m++;
                if (!lk) own_m = -1;
                else if (run_m == LOCK_MAX) begin err_m = 1'b1; own_m = -1; end
            end
        end else begin
            e_rd = 1'b0; e_wr = 1'b0;
            if (own_m >= 0 && !((own_m == 1) ? lock1 : lock0)) own_m = -1;
        end
        rd_prev2 = rd_prev1;
        rd_prev1 = (g >= 0) && !w;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_init();
    endtask

    initial begin
        logic [3:0] seq;
        int         run;
        bit         p0, p1;
        for (int i = 0; i < 16384; i++) shadow[i] = init_val(i);
        model_init();
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", outs(), 64'd0);
        reset = 1'b1;

        // Single read from port 0
        req0 = 1'b1; wr0 = 1'b0; lock0 = 1'b0; addr0 = 14'h0081;
        tick(); chk("A gnt0", snap_gnt0, 1);
        req0 = 1'b0;
        tick(); chk("A res_rd", snap_rd, 1); chk("A res_addr", snap_addr, 14'h0081);
        tick(); tick();
        chk("A rvalid0", snap_rv0, 1); chk("A rdata0", snap_rd0, 8'h05); chk("A rvalid1", snap_rv1, 0);

        // Write at the top address
        req0 = 1'b1; wr0 = 1'b1; addr0 = 14'h3FFF; wdata0 = 8'hFF;
        tick(); chk("B gnt0", snap_gnt0, 1);
        req0 = 1'b0; wr0 = 1'b0;
        tick(); chk("B res", {snap_wr, snap_rd, snap_addr, snap_do}, {1'b1, 1'b0, 14'h3FFF, 8'hFF});
        tick(); tick(); chk("B no rvalid", {snap_rv0, snap_rv1}, 2'b00);

        // Both ports from reset: alternate
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = raddr(); addr1 = raddr();
        seq = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seq = {seq[2:0], snap_gnt1};
            if (snap_gnt0) addr0 = raddr();
            if (snap_gnt1) addr1 = raddr();
        end
        chk("C order", seq, 4'b0101);
        idle(4);

        // Port 1 lock burst while port 0 waits
        req0 = 1'b1; wr0 = 1'b1; addr0 = raddr(); wdata0 = 8'($urandom);
        tick(); chk("D pre gnt0", snap_gnt0, 1);
        wr0 = 1'b0; addr0 = raddr(); req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lock1 = (i < 3); wr1 = 1'($urandom_range(0, 1)); addr1 = raddr(); wdata1 = 8'($urandom);
            tick();
            chk("D gnt1", {snap_gnt1, snap_gnt0}, 2'b10);
            if (i > 0) chk("D busy", snap_busy, 1);
        end
        req1 = 1'b0; lock1 = 1'b0;
        tick(); chk("D gnt0 after", snap_gnt0, 1);
        idle(4);

        // Port 0 lock timeout
        req0 = 1'b1; lock0 = 1'b1; wr0 = 1'b0; addr0 = raddr();
        tick(); chk("E first gnt0", snap_gnt0, 1);
        run = 1; addr0 = raddr(); req1 = 1'b1; wr1 = 1'b0; lock1 = 1'b0; addr1 = raddr();
        for (int k = 0; k < 40 && !snap_gnt1; k++) begin
            tick();
            if (snap_gnt0) begin run++; addr0 = raddr(); end
        end
        chk("E run", run, LOCK_MAX);
        chk("E gnt1", snap_gnt1, 1);
        chk("E lock_err", snap_err, 1);
        req1 = 1'b0;
        tick(); chk("E 17th gnt0", snap_gnt0, 1);
        idle(4); chk("E err sticky", snap_err, 1);

        // Random traffic
        p0 = 1'b0; p1 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!p0) begin
                if ($urandom_range(0, 3) != 0) begin
                    p0 = 1'b1; wr0 = 1'($urandom_range(0, 1)); lock0 = ($urandom_range(0, 5) == 0);
                    addr0 = raddr(); wdata0 = 8'($urandom);
                end else lock0 = lock0 & ($urandom_range(0, 1) == 1);
            end
            if (!p1) begin
                if ($urandom_range(0, 3) != 0) begin
                    p1 = 1'b1; wr1 = 1'($urandom_range(0, 1)); lock1 = ($urandom_range(0, 5) == 0);
                    addr1 = raddr(); wdata1 = 8'($urandom);
                end else lock1 = lock1 & ($urandom_range(0, 1) == 1);
            end
            req0 = p0; req1 = p1;
            tick();
            if (snap_gnt0) p0 = 1'b0;
            if (snap_gnt1) p1 = 1'b0;
        end
        idle(4);

        // Reset one cycle after a read grant
        req0 = 1'b1; wr0 = 1'b0; lock0 = 1'b0; addr0 = raddr();
        tick(); chk("G gnt0", snap_gnt0, 1);
        req1 = 1'b1;
        reset = 1'b0;
        #1;
        chk("G reset outs", outs(), 64'd0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_init();
        idle(4);
        chk("G quiet", {snap_rv0, snap_rv1, snap_busy}, 3'b000);
        req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
        tick(); chk("G first contention", {snap_gnt1, snap_gnt0}, 2'b01);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
